// File: rtl/md_pkg.sv
// +------------------------------------------------------------------+
// | md_pkg : shared MD op codes, FSM states, counter width            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package md_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MADD  = 4'd4;
  localparam logic [3:0] MD_MADDU = 4'd5;
  localparam logic [3:0] MD_MSUB  = 4'd6;
  localparam logic [3:0] MD_MSUBU = 4'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_op_valid(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic md_op_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// +------------------------------------------------------------------+
// | md_arith : combinational 64-bit {hi,lo} result for one MD op      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [63:0] w_hilo;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_b_zero;
  logic        w_ovf;

  assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};
  assign w_hilo  = {i_hi, i_lo};

  // Signed divide on magnitudes: quotient negated when signs differ, remainder follows dividend.
  assign w_abs_a  = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_abs_b  = i_b[31] ? (~i_b + 32'd1) : i_b;
  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  assign w_mag_q = w_b_zero ? 32'd0 : (w_abs_a / w_abs_b);
  assign w_mag_r = w_b_zero ? 32'd0 : (w_abs_a % w_abs_b);
  assign w_sq    = (i_a[31] ^ i_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
  assign w_sr    = i_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
  assign w_uq    = w_b_zero ? 32'd0 : (i_a / i_b);
  assign w_ur    = w_b_zero ? 32'd0 : (i_a % i_b);

  always_comb begin
    o_res = w_hilo;
    case (i_op)
      MD_MULT:  o_res = w_sprod;
      MD_MULTU: o_res = w_uprod;
      MD_MADD:  o_res = w_hilo + w_sprod;
      MD_MADDU: o_res = w_hilo + w_uprod;
      MD_MSUB:  o_res = w_hilo - w_sprod;
      MD_MSUBU: o_res = w_hilo - w_uprod;
      MD_DIV: begin
        if (w_b_zero) begin
          o_res = {i_a, 32'hFFFF_FFFF};
        end else if (w_ovf) begin
          o_res = {32'd0, 32'h8000_0000};
        end else begin
          o_res = {w_sr, w_sq};
        end
      end
      MD_DIVU: begin
        if (w_b_zero) begin
          o_res = {i_a, 32'hFFFF_FFFF};
        end else begin
          o_res = {w_ur, w_uq};
        end
      end
      default: o_res = w_hilo;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// +------------------------------------------------------------------+
// | md_ctrl : HI/LO multiply-divide sequencer with busy and ID stall  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic        flush,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] c_MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_LAT  = CNT_W'(DIV_CYCLES);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_lat;
  logic [3:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [63:0]      w_result;
  logic             w_busy;
  logic             w_acc;
  logic             w_mt_ok;
  logic             w_load;
  logic             w_commit;

  assign w_busy  = (r_state == ST_RUN);
  assign w_acc   = md_start & ~flush & ~w_busy;
  // A start in the same cycle wins; the MT write is dropped.
  assign w_mt_ok = ~md_start & ~flush & ~w_busy;
  assign w_lat   = md_op_is_div(md_op) ? c_DIV_LAT : c_MULT_LAT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && md_op_valid(md_op)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = w_lat;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  md_arith u_arith (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_load) begin
        r_op <= md_op;
        r_a  <= md_a;
        r_b  <= md_b;
      end
      if (w_commit) begin
        r_hi <= w_result[63:32];
        r_lo <= w_result[31:0];
      end else if (w_mt_ok) begin
        if (mt_hi) r_hi <= md_a;
        if (mt_lo) r_lo <= md_a;
      end
    end
  end

  assign busy  = w_busy;
  assign stall = id_md_use & (w_busy | w_acc);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_ctrl.sv
// +------------------------------------------------------------------+
// | tb_md_ctrl : directed + random checks of md_ctrl vs arithmetic ref |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_md_ctrl;
  import md_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        mt_hi;
  logic        mt_lo;
  logic        flush;
  logic        id_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_ctrl #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .mt_hi(mt_hi), .mt_lo(mt_lo), .flush(flush),
    .id_md_use(id_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from plain integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
    longint sp;
    logic [63:0] up;
    int sa, sb, q, r;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    sa = a;
    sb = b;
    case (op)
      MD_MULT:  return sp;
      MD_MULTU: return up;
      MD_MADD:  return hl + sp;
      MD_MADDU: return hl + up;
      MD_MSUB:  return hl - sp;
      MD_MSUBU: return hl - up;
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return hl;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_id, input logic intr);
    int n;
    int lat;
    logic [63:0] e;
    lat = md_op_is_div(op) ? DIV_LAT : MULT_LAT;
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_a = a; md_b = b; id_md_use = use_id;
    #1;
    check("stall_on_start", stall, use_id);
    @(negedge clk);
    md_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check("stall_while_busy", stall, use_id);
      if (intr && n == 1) begin
        md_start = 1'b1; md_op = MD_MULTU; md_a = $urandom; md_b = $urandom;
        mt_hi = 1'b1; mt_lo = 1'b1;
      end else if (intr && n == 2) begin
        md_start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'(lat));
    check("stall_after_busy", stall, 1'b0);
    e = ref_md(op, a, b, {m_hi, m_lo});
    m_hi = e[63:32];
    m_lo = e[31:0];
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    id_md_use = 1'b0;
  endtask

  task automatic mt_write(input logic to_hi, input logic [31:0] v);
    @(negedge clk);
    mt_hi = to_hi; mt_lo = ~to_hi; md_a = v;
    @(negedge clk);
    mt_hi = 1'b0; mt_lo = 1'b0;
    if (to_hi) m_hi = v; else m_lo = v;
    check("mt_hi_val", hi, m_hi);
    check("mt_lo_val", lo, m_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp [4];
    sp[0] = 32'd0; sp[1] = 32'h8000_0000; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'd1;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0; md_start = 1'b0; md_op = '0; md_a = '0; md_b = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; flush = 1'b0; id_md_use = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    id_md_use = 1'b0;

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("multu_hi_const", hi, 32'h2);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    run_op(MD_DIVU,  32'd7, 32'd0, 1'b0, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    mt_write(1'b1, 32'd5);
    mt_write(1'b0, 32'hFFFF_FFFF);
    run_op(MD_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
    check("maddu_hi_const", hi, 32'd6);
    run_op(MD_MSUB,  32'd1, 32'd1, 1'b0, 1'b0);
    check("msub_lo_const", lo, 32'hFFFF_FFFF);

    // Flushed start must not launch anything.
    @(negedge clk);
    md_start = 1'b1; md_op = MD_MULT; md_a = 32'd9; md_b = 32'd9; flush = 1'b1; id_md_use = 1'b1;
    #1;
    check("flush_stall", stall, 1'b0);
    @(negedge clk);
    md_start = 1'b0; flush = 1'b0; id_md_use = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);

    // Unknown op code is accepted but does nothing.
    @(negedge clk);
    md_start = 1'b1; md_op = 4'hF; md_a = 32'h1234; md_b = 32'h5;
    @(negedge clk);
    md_start = 1'b0;
    check("badop_busy", busy, 1'b0);
    check("badop_hi", hi, m_hi);
    check("badop_lo", lo, m_lo);

    // Start and MT writes while busy are ignored.
    run_op(MD_MULT, 32'h0001_0003, 32'hFFFF_0007, 1'b1, 1'b1);
    run_op(MD_DIV,  32'h7FFF_FFFF, 32'hFFFF_FFF3, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      run_op(4'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset mid-divide.
    mt_write(1'b1, 32'hA5A5_0001);
    mt_write(1'b0, 32'h5A5A_0002);
    @(negedge clk);
    md_start = 1'b1; md_op = MD_DIV; md_a = 32'd100; md_b = 32'd7;
    @(negedge clk);
    md_start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    #10;
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    run_op(MD_MULT, 32'h0000_1234, 32'hFFFF_FF00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
